// File: rtl/jrb8_mem_pkg.sv
// Shared types and constants for the SPI memory arbiter.
package jrb8_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mem_state_t;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } mem_req_t;

  // Read data returned to the requester when the engine never answers.
  localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last time.
module spi_rr_arbiter
  import jrb8_mem_pkg::*;
(
  input  logic     fetch_req,
  input  logic     data_req,
  input  mem_req_t last_grant,
  output mem_req_t gnt,
  output logic     valid
);

  // Pick the winner among the active requests.
  always_comb begin
    gnt   = REQ_FETCH;
    valid = fetch_req | data_req;
    if (fetch_req && data_req) begin
      gnt = (last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (data_req) begin
      gnt = REQ_DATA;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory engine between instruction fetch (ROM) and data
// access (RAM). Grants in IDLE, holds the engine start through BUSY, and
// pulses the winner's done in DONE. Stuck engines are aborted after TIMEOUT
// BUSY cycles with all-ones read data and a sticky err flag.
module spi_mem_arbiter
  import jrb8_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              spi_start,
  output logic              spi_write,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rdata,
  output logic              rom_sel,
  output logic              ram_sel,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state, state_nxt;
  mem_req_t         cur_req, last_grant, gnt;
  logic             gnt_vld;
  logic [CNT_W-1:0] cnt;
  logic             timeout, abort;

  spi_rr_arbiter u_arb (
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .valid      (gnt_vld)
  );

  // A coincident spi_done always takes precedence over the timeout abort.
  assign timeout = (cnt == CNT_LAST);
  assign abort   = (state == ST_BUSY) && timeout && !spi_done;

  // Outputs decode straight from state so reset drops them without a clock.
  assign spi_start  = (state == ST_BUSY);
  assign rom_sel    = spi_start && (cur_req == REQ_FETCH);
  assign ram_sel    = spi_start && (cur_req == REQ_DATA);
  assign busy       = (state != ST_IDLE);
  assign fetch_done = (state == ST_DONE) && (cur_req == REQ_FETCH);
  assign data_done  = (state == ST_DONE) && (cur_req == REQ_DATA);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_vld) state_nxt = ST_BUSY;
      ST_BUSY: if (spi_done || timeout) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant latch, BUSY cycle counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_req     <= REQ_FETCH;
      last_grant  <= REQ_DATA;
      cnt         <= '0;
      spi_write   <= 1'b0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      if (state == ST_IDLE && gnt_vld) begin
        cur_req    <= gnt;
        last_grant <= gnt;
        cnt        <= '0;
        if (gnt == REQ_FETCH) begin
          spi_addr  <= fetch_addr;
          spi_write <= 1'b0;
        end else begin
          spi_addr  <= data_addr;
          spi_write <= data_we;
          spi_wdata <= data_wdata;
        end
      end
      if (state == ST_BUSY) begin
        if (!timeout) cnt <= cnt + CNT_W'(1);
        if (spi_done) begin
          if (cur_req == REQ_FETCH) fetch_rdata <= spi_rdata;
          else if (!spi_write)      data_rdata  <= spi_rdata;
        end else if (timeout) begin
          if (cur_req == REQ_FETCH) fetch_rdata <= DATA_W'(ERR_RDATA);
          else                      data_rdata  <= DATA_W'(ERR_RDATA);
        end
      end
    end
  end

  // Sticky error flag; a new abort beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (abort)   err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  // Engine chip-select must only ever reach one device.
  assert property (@(posedge clk) disable iff (!rst_n) !(rom_sel && ram_sel));

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Randomized bench for spi_mem_arbiter with a transaction-level reference
// model (round-robin winner, expected busy length, result data, err flag).
module tb_spi_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req, data_req, data_we, spi_done, err_clr;
  logic [ADDR_W-1:0] fetch_addr, data_addr;
  logic [DATA_W-1:0] data_wdata, spi_rdata;
  logic              fetch_done, data_done, spi_start, spi_write;
  logic              rom_sel, ram_sel, busy, err;
  logic [DATA_W-1:0] fetch_rdata, data_rdata, spi_wdata;
  logic [ADDR_W-1:0] spi_addr;

  spi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_done  (fetch_done),
    .fetch_rdata (fetch_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_done   (data_done),
    .data_rdata  (data_rdata),
    .spi_start   (spi_start),
    .spi_write   (spi_write),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata),
    .rom_sel     (rom_sel),
    .ram_sel     (ram_sel),
    .busy        (busy),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: last grant (1 = data), result registers, err.
  bit       m_last;
  bit [7:0] m_frd, m_drd;
  bit       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_frd  = 8'h00;
    m_drd  = 8'h00;
    m_err  = 1'b0;
  endtask

  // Idle cycles with stray engine pulses that must be ignored.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      spi_done  = 1'($urandom_range(0, 1));
      spi_rdata = 8'($urandom);
      @(posedge clk); @(negedge clk);
      spi_done = 1'b0;
      chk("idle_state", 32'({busy, fetch_done, data_done, fetch_rdata, data_rdata}),
          32'({3'b000, m_frd, m_drd}));
    end
  endtask

  // One arbitrated transaction, starting and ending on an IDLE negedge.
  task automatic do_txn(input bit fr, input bit dr, input logic [15:0] fa, input logic [15:0] da,
                        input bit dwe, input logic [7:0] dwd, input logic [7:0] rd,
                        input int delay, input bit stall, input bit hold, input bit chg,
                        input bit clr, input bit drop);
    bit          w;
    logic [15:0] ea;
    bit          ewe;
    int          nb, exp_nb;
    bit          got_done, sel_bad;
    w      = (fr && dr) ? ~m_last : dr;
    m_last = w;
    ea     = w ? da : fa;
    ewe    = w ? dwe : 1'b0;
    fetch_req = fr; fetch_addr = fa;
    data_req  = dr; data_addr  = da; data_we = dwe; data_wdata = dwd;
    @(posedge clk); @(negedge clk);
    chk("busy_entry", 32'({spi_start, busy, rom_sel, ram_sel}), 32'({2'b11, ~w, w}));
    chk("spi_addr", 32'(spi_addr), 32'(ea));
    chk("spi_write", 32'(spi_write), 32'(ewe));
    if (w) chk("spi_wdata", 32'(spi_wdata), 32'(dwd));
    err_clr  = clr;
    exp_nb   = stall ? TIMEOUT : delay + 1;
    nb       = 0;
    got_done = 1'b0;
    sel_bad  = 1'b0;
    while (nb < TIMEOUT + 8) begin
      if (fetch_done || data_done) begin
        got_done = 1'b1;
        break;
      end
      if (rom_sel !== ~w || ram_sel !== w || spi_start !== 1'b1 || spi_addr !== ea) sel_bad = 1'b1;
      if (nb == 1 && chg) begin
        fetch_addr = 16'($urandom); data_addr = 16'($urandom);
        data_wdata = 8'($urandom);  data_we   = ~data_we;
      end
      if (nb == 1 && drop) begin
        fetch_req = 1'b0; data_req = 1'b0;
      end
      spi_done  = !stall && (nb == delay);
      spi_rdata = spi_done ? rd : 8'($urandom);
      @(posedge clk); @(negedge clk);
      spi_done = 1'b0;
      nb++;
    end
    if (stall) begin
      if (w) m_drd = 8'hFF; else m_frd = 8'hFF;
      m_err = 1'b1;
    end else begin
      if (!w) m_frd = rd;
      else if (!ewe) m_drd = rd;
      if (clr) m_err = 1'b0;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("busy_len", 32'(nb), 32'(exp_nb));
    chk("busy_hold", 32'(sel_bad), 32'd0);
    chk("done_pulse", 32'({fetch_done, data_done, spi_start, rom_sel, ram_sel, busy}),
        32'({~w, w, 4'b0001}));
    chk("rdata", 32'({fetch_rdata, data_rdata}), 32'({m_frd, m_drd}));
    chk("err", 32'(err), 32'(m_err));
    chk("spi_addr_done", 32'(spi_addr), 32'(ea));
    err_clr = 1'b0;
    if (!hold) begin
      fetch_req = 1'b0; data_req = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk("back_idle", 32'({busy, fetch_done, data_done}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat, dly;
    bit st;
    rst_n = 1'b1;
    fetch_req = 0; data_req = 0; data_we = 0; spi_done = 0; err_clr = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; spi_rdata = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", 32'({fetch_done, data_done, spi_start, spi_write, rom_sel, ram_sel, busy, err}), 32'd0);
    chk("reset_regs", 32'({fetch_rdata, data_rdata, spi_wdata}), 32'd0);
    chk("reset_addr", 32'(spi_addr), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset: fetch, data, fetch, data.
    for (int i = 0; i < 4; i++)
      do_txn(1, 1, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0, 8'h00, 8'(8'h50 + i),
             2, 0, (i < 3), 0, 0, 0);
    fetch_req = 0; data_req = 0;
    idle_gap(1);

    // Fetch only, changing the fetch address mid-BUSY.
    do_txn(1, 0, 16'h0012, 16'h0000, 1'b0, 8'h00, 8'hA5, 5, 0, 0, 1, 0, 0);
    // Data write leaves data_rdata untouched.
    do_txn(0, 1, 16'h0000, 16'h0340, 1'b1, 8'h3C, 8'h77, 3, 0, 0, 0, 0, 0);
    // Stalled engine on a read, then clear err.
    do_txn(0, 1, 16'h0000, 16'h0555, 1'b0, 8'h00, 8'h11, 0, 1, 0, 0, 0, 0);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    // Stall with err_clr held: the new error wins.
    do_txn(1, 0, 16'h0777, 16'h0000, 1'b0, 8'h00, 8'h22, 0, 1, 0, 0, 1, 0);
    // spi_done on the last BUSY cycle is a normal completion.
    do_txn(1, 0, 16'h0888, 16'h0000, 1'b0, 8'h00, 8'h5A, TIMEOUT - 1, 0, 0, 0, 1, 0);

    // Reset in BUSY drops everything at once.
    fetch_req = 1'b1; fetch_addr = 16'h0BEE;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_busy", 32'(spi_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({spi_start, rom_sel, ram_sel, busy, fetch_done, data_done}), 32'd0);
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle_gap(3);
    do_txn(1, 1, 16'h0AAA, 16'h0BBB, 1'b0, 8'h00, 8'hC3, 1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      pat = $urandom_range(0, 2);
      st  = ($urandom_range(0, 9) == 0);
      dly = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 12);
      do_txn(pat != 1, pat != 0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             8'($urandom), 8'($urandom), dly, st, 0, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
      idle_gap($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
